// File: rtl/seg_pkg.sv
// seg_pkg: shared key debounce states and default timing constants for the segment display front end
package seg_pkg;
    typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} key_state_e;
    localparam int CLK_HZ = 50_000_000;
    localparam int DEB_MAX_DEF = CLK_HZ / 50;
    localparam int TICK_MAX_DEF = CLK_HZ / 2;
endpackage

// File: rtl/key_debounce.sv
// key_debounce: synchronises and debounces an active-low key, giving a press strobe and the clean level
module key_debounce
    import seg_pkg::*;
#(
    parameter int DEB_MAX = DEB_MAX_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic press_evt,
    output logic key_state
);
    localparam int W = $clog2(DEB_MAX);
    localparam logic [W-1:0] DEB_LAST = W'(DEB_MAX - 1);
    logic s1, key_sync;
    logic [W-1:0] deb_cnt;
    key_state_e state;
    assign press_evt = state == PRESS_WAIT && !key_sync && deb_cnt == DEB_LAST;
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b1;
            key_sync <= 1'b1;
            state <= IDLE;
            deb_cnt <= '0;
            key_state <= 1'b0;
        end else begin
            s1 <= key_in;
            key_sync <= s1;
            case (state)
                IDLE: if (!key_sync) begin
                    state <= PRESS_WAIT;
                    deb_cnt <= '0;
                end
                PRESS_WAIT: if (key_sync) state <= IDLE;
                else if (deb_cnt == DEB_LAST) begin
                    state <= PRESSED;
                    deb_cnt <= '0;
                    key_state <= 1'b1;
                end else deb_cnt <= deb_cnt + W'(1);
                PRESSED: if (key_sync) begin
                    state <= RELEASE_WAIT;
                    deb_cnt <= '0;
                end
                RELEASE_WAIT: if (!key_sync) state <= PRESSED;
                else if (deb_cnt == DEB_LAST) begin
                    state <= IDLE;
                    deb_cnt <= '0;
                    key_state <= 1'b0;
                end else deb_cnt <= deb_cnt + W'(1);
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: rtl/seg_flag_gen.sv
// seg_flag_gen: merges debounced key presses and an optional period timer into one advance strobe
module seg_flag_gen
    import seg_pkg::*;
#(
    parameter int DEB_MAX = DEB_MAX_DEF,
    parameter int TICK_MAX = TICK_MAX_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    input  logic auto_en,
    output logic add_flag,
    output logic key_state
);
    localparam int TW = $clog2(TICK_MAX);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_MAX - 1);
    logic press_evt, tick_evt;
    logic [TW-1:0] tick_cnt;
    key_debounce #(.DEB_MAX(DEB_MAX)) u_deb (
        .clk(clk),
        .rst(rst),
        .key_in(key_in),
        .press_evt(press_evt),
        .key_state(key_state)
    );
    assign tick_evt = auto_en && tick_cnt == TICK_LAST;
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
            add_flag <= 1'b0;
        end else begin
            tick_cnt <= (!auto_en || tick_evt || press_evt) ? '0 : tick_cnt + TW'(1);
            add_flag <= press_evt | tick_evt;
        end
    end
endmodule

// File: tb/tb_seg_flag_gen.sv
// tb_seg_flag_gen: table, directed and randomized checks of seg_flag_gen against a run-length/absolute-time model
module tb_seg_flag_gen;
    localparam int DEB = 4;
    localparam int TM = 10;
    logic clk = 1'b0, rst = 1'b1, key_in = 1'b1, auto_en = 1'b0;
    logic add_flag, key_state;
    int errors = 0, checks = 0, ed = 0;
    logic m_s1, m_sync;
    bit m_pressed, armed, m_flag, m_state;
    int low_run, high_run, next_tick, m_edge = 0;

    typedef struct {
        logic key;
        logic auto_v;
        logic rst_v;
        logic exp_flag;
        logic exp_state;
    } vec_t;
    vec_t tbl[$];

    seg_flag_gen #(.DEB_MAX(DEB), .TICK_MAX(TM)) dut (
        .clk(clk),
        .rst(rst),
        .key_in(key_in),
        .auto_en(auto_en),
        .add_flag(add_flag),
        .key_state(key_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s edge=%0d got=%b want=%b", nm, ed, act, exp);
        end
    endtask

    // press = DEB+1 consecutive low synced samples while released; release likewise with highs
    task automatic model_edge(input logic k, input logic a, input logic r);
        bit press, tick;
        if (r) begin
            m_s1 = 1'b1; m_sync = 1'b1; m_pressed = 0; armed = 0;
            low_run = 0; high_run = 0; m_flag = 0; m_state = 0;
        end else begin
            press = 0;
            if (m_sync) begin high_run++; low_run = 0; end
            else begin low_run++; high_run = 0; end
            if (!m_pressed && low_run == DEB + 1) begin m_pressed = 1; press = 1; end
            else if (m_pressed && high_run == DEB + 1) m_pressed = 0;
            tick = a && armed && m_edge == next_tick;
            if (!a) armed = 0;
            else begin
                if (press || tick) next_tick = m_edge + TM;
                else if (!armed) next_tick = m_edge + TM - 1;
                armed = 1;
            end
            m_flag = press | tick;
            m_state = m_pressed;
            m_sync = m_s1;
            m_s1 = k;
        end
        m_edge++;
    endtask

    task automatic step(input logic k, input logic a, input logic r);
        key_in = k; auto_en = a; rst = r;
        @(posedge clk);
        model_edge(k, a, r);
        #1;
        chk("model_flag", add_flag, m_flag);
        chk("model_state", key_state, m_state);
        ed++;
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b1);
        ed = 0;
    endtask

    initial begin
        tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
        for (int i = 0; i < 20; i++) tbl.push_back('{1'b0, 1'b0, 1'b0, logic'(i == 6), logic'(i >= 6)});
        for (int j = 0; j < 12; j++) tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, logic'(j < 6)});
        for (int g = 0; g < 13; g++) tbl.push_back('{logic'(g >= 3), 1'b0, 1'b0, 1'b0, 1'b0});
        foreach (tbl[i]) begin
            step(tbl[i].key, tbl[i].auto_v, tbl[i].rst_v);
            chk("tbl_flag", add_flag, tbl[i].exp_flag);
            chk("tbl_state", key_state, tbl[i].exp_state);
        end

        do_reset();
        for (int e = 0; e < 35; e++) begin
            step(1'b1, 1'b1, 1'b0);
            chk("auto_flag", add_flag, logic'(e inside {9, 19, 29}));
        end

        do_reset();
        for (int e = 0; e < 32; e++) begin
            step(logic'(!(e >= 13 && e < 25)), 1'b1, 1'b0);
            chk("collide_flag", add_flag, logic'(e inside {9, 19, 29}));
        end

        do_reset();
        for (int e = 0; e < 28; e++) begin
            step(logic'(!(e >= 8 && e < 21)), 1'b1, 1'b0);
            chk("rephase_flag", add_flag, logic'(e inside {9, 14, 24}));
        end

        do_reset();
        for (int e = 0; e < 31; e++) begin
            step(logic'(e inside {[12:13]} || e >= 20), 1'b0, 1'b0);
            chk("bounce_flag", add_flag, logic'(e == 6));
            chk("bounce_state", key_state, logic'(e >= 6 && e < 26));
        end

        do_reset();
        for (int e = 0; e < 16; e++) begin
            step(1'b0, 1'b0, logic'(e == 4));
            chk("rstmid_flag", add_flag, logic'(e == 11));
            chk("rstmid_state", key_state, logic'(e >= 11));
        end

        do_reset();
        begin
            logic k = 1'b1, a = 1'b0;
            int run = 0;
            for (int n = 0; n < 4000; n++) begin
                if (run == 0) begin
                    k = logic'($urandom_range(0, 1));
                    run = $urandom_range(1, 2 * DEB + 3);
                end
                run--;
                if ($urandom_range(0, 59) == 0) a = ~a;
                step(k, a, logic'($urandom_range(0, 499) == 0));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/seg_flag_gen.md
Name: seg_flag_gen

Overview:
- Upstream stage of the static seven-segment display driver; produces its single-cycle `add_flag` "advance digit" strobe.
- Two strobe sources, merged into one registered output:
  - a debounced push-key, giving one strobe per clean press;
  - an optional free-running period timer, enabled by `auto_en`.
- Also exports the debounced key level for LEDs or other consumers.

Parameters:
- DEB_MAX, 1_000_000: cycles `key_sync` must be stable to accept a press or release (20 ms @ 50 MHz); must be ≥ 2.
- TICK_MAX, 25_000_000: auto-advance period in cycles (0.5 s @ 50 MHz); must be ≥ 2.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- key_in  input  1  raw asynchronous push-key, active-low (0 = pressed).
- auto_en  input  1  1 = periodic strobe enabled; synchronous to clk.
- add_flag  output  1  one-cycle strobe to the display driver; registered.
- key_state  output  1  debounced key level, 1 = pressed; registered.

Behaviour:
- Reset (rst = 1 at an edge) forces:
  - sync FFs = 1, FSM = IDLE;
  - deb_cnt = 0, tick_cnt = 0;
  - add_flag = 0, key_state = 0.
  - Reset mid-operation abandons any debounce or period in progress. No strobe appears in the cycle after reset.
- Synchroniser: two flops on key_in produce `key_sync`, which lags key_in by 2 edges.
- Debounce FSM: states IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
  - IDLE: key_sync = 0 → PRESS_WAIT, deb_cnt ← 0.
  - PRESS_WAIT, key_sync = 1 → IDLE (glitch rejected, no strobe).
  - PRESS_WAIT, key_sync = 0: deb_cnt++. At an edge where deb_cnt == DEB_MAX-1 → PRESSED and press_evt = 1 for that edge.
  - PRESSED: key_sync = 1 → RELEASE_WAIT, deb_cnt ← 0.
  - RELEASE_WAIT, key_sync = 0 → PRESSED (bounce, no strobe).
  - RELEASE_WAIT, key_sync = 1: deb_cnt++. At deb_cnt == DEB_MAX-1 → IDLE.
  - Release generates no strobe.
- key_state = 1 while FSM ∈ {PRESSED, RELEASE_WAIT}, registered with the state.
- Press latency: with key_in held low from edge 0 (first edge sampling 0), add_flag is high in the cycle after edge DEB_MAX+2, for exactly 1 cycle.
- Timer, auto_en = 0: tick_cnt ← 0 and tick_evt = 0.
- Timer, auto_en = 1:
  - tick_cnt increments modulo TICK_MAX.
  - At an edge where tick_cnt == TICK_MAX-1: tick_cnt ← 0, tick_evt = 1.
  - First strobe follows edge TICK_MAX-1 after auto_en is first sampled high; period is then exactly TICK_MAX cycles.
- Merge: add_flag ← press_evt | tick_evt.
  - press_evt and tick_evt on the same edge → a single one-cycle strobe, never two.
- Re-phase: press_evt with auto_en = 1 forces tick_cnt ← 0, so the next auto strobe is TICK_MAX cycles after the press strobe.
- auto_en drop mid-period discards the partial count; no strobe.
- Key held through reset release: key_sync = 0 at IDLE, so a press is detected after normal debounce. This is intended.
- Widths: deb_cnt is $clog2(DEB_MAX) bits; tick_cnt is $clog2(TICK_MAX) bits. Counters never exceed MAX-1.

Decomposition:
- Shared package seg_pkg holds:
  - typedef key_state_e {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT};
  - constants CLK_HZ = 50_000_000, DEB_MAX_DEF and TICK_MAX_DEF.
- One sub-module, key_debounce (synchroniser, FSM, deb_cnt; outputs press_evt and key_state), is reused by other key-driven blocks.
- Timer and merge stay in seg_flag_gen.

Test Plan:
- Use DEB_MAX = 4, TICK_MAX = 10 for all scenarios.
- Clean press: auto_en = 0, key_in 1→0 sampled at edge 0 and held 20 cycles → add_flag high only in the cycle after edge 6; key_state = 1 from edge 6.
- Glitch: key_in low for 3 cycles, then high → add_flag never asserts; key_state stays 0; FSM returns to IDLE.
- Auto mode: auto_en = 1 from edge 0, key idle → add_flag after edges 9, 19, 29…; exactly one cycle each.
- Collision / re-phase:
  - Press timed so press_evt coincides with tick edge 19 → single one-cycle strobe; next strobe after edge 29.
  - Press strobe at edge 14 → next auto strobe after edge 24.
- Release bounce: while pressed, key_in high 2 cycles then low → key_state stays 1, no strobe. Full release → key_state = 0 after DEB_MAX+3 edges.
- Reset mid-debounce: rst = 1 for 1 cycle during PRESS_WAIT with key held low → outputs 0; a fresh press is detected 7 edges after reset release; no strobe on the reset cycle.
